sipo_deser: RTL and testbench

Serial-in/parallel-out deserializer: receiving end of the team's mux-based parallel-to-serial link. It accepts one bit per cycle over a valid/ready handshake, assembles LSB-first words of WIDTH bits, and presents each word on a parallel valid/ready output. It sits between the serial link and the word-level datapath (register bank / ALU operand inputs).

---
 rtl/deser_pkg.sv | 19 +
 rtl/deser_bit_cnt.sv | 29 ++
 rtl/sipo_deser.sv | 126 ++++++++++++
 tb/tb_sipo_deser.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared types and constants for the sipo_deser serial-to-word receiver.
package deser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Even parity: XOR over data bits and parity bit must equal this value.
  localparam logic PARITY_POL = 1'b0;

  // Zero-extended data does not change the XOR reduction, so one width serves all words.
  function automatic logic parity_fail(input logic [31:0] data, input logic pbit);
    return (^data ^ pbit) != PARITY_POL;
  endfunction

endpackage

// File: rtl/deser_bit_cnt.sv
// Bit-position counter for sipo_deser: load-to-1, saturating increment, clear, terminal flag.
module deser_bit_cnt #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             last_c
);

  assign last_c = (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(1);
    end else if (inc && !last_c) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: LSB-first words over valid/ready on both sides.
// Optional even-parity bit per word when DESER_PARITY_EN is defined.
module sipo_deser
  import deser_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_start,
  input  logic             sin_valid,
  output logic             sin_ready,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             sync_err,
  output logic             parity_err
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             last_c;
  logic             accept_c;
  logic             cnt_load_c;
  logic             cnt_inc_c;
  logic             cnt_clr_c;

  assign accept_c = sin_valid && sin_ready;

  // Counter control: start bits reload, data bits advance, last data bit wraps to 0.
  always_comb begin
    cnt_load_c = 1'b0;
    cnt_inc_c  = 1'b0;
    cnt_clr_c  = 1'b0;
    if (accept_c) begin
      if (sin_start && state != HOLD) begin
        cnt_load_c = 1'b1;
      end else if (state == SHIFT) begin
        if (last_c) cnt_clr_c = 1'b1;
        else        cnt_inc_c = 1'b1;
      end
    end
  end

  deser_bit_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (cnt_load_c),
    .inc    (cnt_inc_c),
    .clr    (cnt_clr_c),
    .count  (count),
    .last_c (last_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pout       <= '0;
      pout_valid <= 1'b0;
      sin_ready  <= 1'b1;
      sync_err   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c && sin_start) begin
            pout[0] <= sin;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (accept_c) begin
            if (sin_start) begin
              pout     <= WIDTH'(sin);
              sync_err <= 1'b1;
            end else begin
              pout[count] <= sin;
              if (last_c) begin
`ifdef DESER_PARITY_EN
                state      <= PAR;
`else
                state      <= HOLD;
                pout_valid <= 1'b1;
                sin_ready  <= 1'b0;
`endif
              end
            end
          end
        end
`ifdef DESER_PARITY_EN
        // Word is complete in pout here; the accepted bit is its parity.
        PAR: begin
          if (accept_c) begin
            if (sin_start) begin
              pout     <= WIDTH'(sin);
              sync_err <= 1'b1;
              state    <= SHIFT;
            end else begin
              parity_err <= parity_fail(32'(pout), sin);
              state      <= HOLD;
              pout_valid <= 1'b1;
              sin_ready  <= 1'b0;
            end
          end
        end
`endif
        HOLD: begin
          if (pout_ready) begin
            state      <= IDLE;
            pout_valid <= 1'b0;
            sin_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// Directed self-checking bench for sipo_deser (WIDTH=8); parity cases when DESER_PARITY_EN is defined.
module tb_sipo_deser;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             sin;
  logic             sin_start;
  logic             sin_valid;
  logic             sin_ready;
  logic [WIDTH-1:0] pout;
  logic             pout_valid;
  logic             pout_ready;
  logic             sync_err;
  logic             parity_err;

  int n_chk;
  int n_err;
`ifdef DESER_PARITY_EN
  logic par_flip;
`endif

  sipo_deser #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .sin_start  (sin_start),
    .sin_valid  (sin_valid),
    .sin_ready  (sin_ready),
    .pout       (pout),
    .pout_valid (pout_valid),
    .pout_ready (pout_ready),
    .sync_err   (sync_err),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic st);
    sin       = b;
    sin_start = st;
    sin_valid = 1'b1;
    step();
  endtask

  // Sends 8 data bits LSB-first, plus the parity bit when parity is enabled.
  task automatic send_word(input logic [7:0] d);
    for (int i = 0; i < 8; i++) send_bit(d[i], i == 0);
`ifdef DESER_PARITY_EN
    send_bit(^d ^ par_flip, 1'b0);
`endif
  endtask

  task automatic idle_step();
    sin_valid = 1'b0;
    sin_start = 1'b0;
    sin       = 1'b0;
    step();
  endtask

  initial begin
    logic [7:0] w;
    n_chk = 0;
    n_err = 0;
`ifdef DESER_PARITY_EN
    par_flip = 1'b0;
`endif
    rst_n = 1'b0; sin = 1'b0; sin_start = 1'b0; sin_valid = 1'b0; pout_ready = 1'b0;
    #12;
    chk("rst_pout", 32'(pout), 32'h0);
    chk("rst_pout_valid", 32'(pout_valid), 32'h0);
    chk("rst_sin_ready", 32'(sin_ready), 32'h1);
    chk("rst_sync_err", 32'(sync_err), 32'h0);
    chk("rst_parity_err", 32'(parity_err), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Word 0xA5, continuous valid, consumer ready.
    pout_ready = 1'b1;
    w = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      send_bit(w[i], i == 0);
      if (i == 6) chk("t1_valid_early", 32'(pout_valid), 32'h0);
    end
`ifdef DESER_PARITY_EN
    chk("t1_valid_before_par", 32'(pout_valid), 32'h0);
    send_bit(1'b0, 1'b0);
`endif
    chk("t1_valid", 32'(pout_valid), 32'h1);
    chk("t1_pout", 32'(pout), 32'hA5);
    chk("t1_sin_ready_hold", 32'(sin_ready), 32'h0);
    chk("t1_parity_err", 32'(parity_err), 32'h0);
    idle_step();
    chk("t1_valid_drop", 32'(pout_valid), 32'h0);
    chk("t1_sin_ready_back", 32'(sin_ready), 32'h1);
    chk("t1_pout_kept", 32'(pout), 32'hA5);

    // Same word under backpressure; next word's start bit presented throughout.
    pout_ready = 1'b0;
    send_word(8'hA5);
    sin = 1'b1; sin_start = 1'b1; sin_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_valid", 32'(pout_valid), 32'h1);
      chk("t2_hold_pout", 32'(pout), 32'hA5);
      chk("t2_hold_sin_ready", 32'(sin_ready), 32'h0);
    end
    pout_ready = 1'b1;
    step();
    chk("t2_release_valid", 32'(pout_valid), 32'h0);
    chk("t2_release_sin_ready", 32'(sin_ready), 32'h1);
    chk("t2_release_pout", 32'(pout), 32'hA5);
    step();
    chk("t2_first_bit_sync", 32'(sync_err), 32'h0);

    // Aborted word (3 bits of 1 over 0xA5 -> 0xA7), then restart with 0x3C.
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("t3_partial_pout", 32'(pout), 32'hA7);
    chk("t3_partial_valid", 32'(pout_valid), 32'h0);
    w = 8'h3C;
    send_bit(w[0], 1'b1);
    chk("t3_sync_err", 32'(sync_err), 32'h1);
    chk("t3_restart_pout", 32'(pout), 32'h00);
    send_bit(w[1], 1'b0);
    chk("t3_sync_err_once", 32'(sync_err), 32'h0);
    for (int i = 2; i < 8; i++) send_bit(w[i], 1'b0);
`ifdef DESER_PARITY_EN
    send_bit(1'b0, 1'b0);
`endif
    chk("t3_valid", 32'(pout_valid), 32'h1);
    chk("t3_pout", 32'(pout), 32'h3C);
    chk("t3_parity_err", 32'(parity_err), 32'h0);
    idle_step();
    chk("t3_valid_drop", 32'(pout_valid), 32'h0);

    // Bits without start in IDLE are discarded.
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    chk("t4_idle_pout", 32'(pout), 32'h3C);
    chk("t4_idle_valid", 32'(pout_valid), 32'h0);
    chk("t4_idle_sin_ready", 32'(sin_ready), 32'h1);

    // 0xFF with sin_valid toggling; invalid cycles carry start=1 and must be ignored.
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, i == 0);
      if (i < 7) begin
        sin = 1'b0; sin_start = 1'b1; sin_valid = 1'b0;
        step();
      end
      if (i == 3) begin
        chk("t4_mid_pout", 32'(pout), 32'h3F);
        chk("t4_mid_valid", 32'(pout_valid), 32'h0);
        chk("t4_mid_sync_err", 32'(sync_err), 32'h0);
      end
      if (i == 6) chk("t4_valid_early", 32'(pout_valid), 32'h0);
    end
`ifdef DESER_PARITY_EN
    send_bit(1'b0, 1'b0);
`endif
    chk("t4_valid", 32'(pout_valid), 32'h1);
    chk("t4_pout", 32'(pout), 32'hFF);
    idle_step();
    chk("t4_valid_drop", 32'(pout_valid), 32'h0);

    // Reset after 4 bits of a word; then a clean 0x5A.
    send_word(8'h00);
    idle_step();
    for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0);
    #2;
    rst_n = 1'b0;
    sin_valid = 1'b0;
    #1;
    chk("t5_async_pout", 32'(pout), 32'h0);
    chk("t5_async_valid", 32'(pout_valid), 32'h0);
    chk("t5_async_sin_ready", 32'(sin_ready), 32'h1);
    @(negedge clk) rst_n = 1'b1;
    step();
    w = 8'h5A;
    send_bit(w[0], 1'b1);
    chk("t5_no_sync_err", 32'(sync_err), 32'h0);
    chk("t5_first_pout", 32'(pout), 32'h00);
    for (int i = 1; i < 8; i++) send_bit(w[i], 1'b0);
`ifdef DESER_PARITY_EN
    send_bit(1'b0, 1'b0);
`endif
    chk("t5_valid", 32'(pout_valid), 32'h1);
    chk("t5_pout", 32'(pout), 32'h5A);
    chk("t5_parity_err", 32'(parity_err), 32'h0);
    idle_step();

`ifdef DESER_PARITY_EN
    // Good and bad parity on 0xA5.
    par_flip = 1'b0;
    send_word(8'hA5);
    chk("t6_good_parity", 32'(parity_err), 32'h0);
    chk("t6_good_pout", 32'(pout), 32'hA5);
    idle_step();
    par_flip = 1'b1;
    send_word(8'hA5);
    chk("t6_bad_parity", 32'(parity_err), 32'h1);
    chk("t6_bad_valid", 32'(pout_valid), 32'h1);
    idle_step();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
